// File: rtl/hazard_scoreboard.sv
`timescale 1ns/1ps
// Hazard scoreboard: tracks in-flight producers after D, decides stalls
// and operand forwarding for D and E, and owns the mult/div busy counter.
module hazard_scoreboard #(
  parameter int STAGES  = 3,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10,
  localparam int SW     = $clog2(STAGES+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_rs_used,
  input  logic          d_rt_used,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic          d_wen,
  input  logic [AW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  output logic          stall,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          id_ex_clr,
  output logic [SW-1:0] fwd_rs_d,
  output logic [SW-1:0] fwd_rt_d,
  output logic [SW-1:0] fwd_rs_e,
  output logic [SW-1:0] fwd_rt_e,
  output logic          md_busy
);

  localparam int CMAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CW   = $clog2(CMAX+1);

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
    logic          md_start;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          rs_used;
    logic          rt_used;
  } rec_t;

  typedef struct packed {
    logic [SW-1:0] k;
    logic [TW-1:0] tnew;
  } hit_t;

  rec_t [STAGES:1] rec;
  rec_t [STAGES:1] rec_nxt;
  logic [CW-1:0]   cnt;

  hit_t rs_d, rt_d, rs_e, rt_e;
  logic raw_stall;
  logic md_stall;
  logic unused;

  // Scan oldest to youngest so the youngest match overwrites the rest.
  function automatic hit_t pick(
    input rec_t [STAGES:1] r,
    input logic [AW-1:0]   s,
    input int              lo
  );
    hit_t h;
    h = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (k >= lo && r[k].valid && r[k].wen &&
          r[k].dst == s && s != '0) begin
        h.k    = SW'(k);
        h.tnew = r[k].tnew;
      end
    end
    return h;
  endfunction

  always_comb begin
    rs_d = pick(rec, d_rs, 1);
    rt_d = pick(rec, d_rt, 1);
    rs_e = pick(rec, rec[1].rs, 2);
    rt_e = pick(rec, rec[1].rt, 2);
    raw_stall =
      (d_rs_used && rs_d.k != '0 && rs_d.tnew > d_rs_tuse) ||
      (d_rt_used && rt_d.k != '0 && rt_d.tnew > d_rt_tuse);
    md_stall = d_md_use &&
      (md_busy || (rec[1].valid && rec[1].md_start));
  end

  assign stall     = raw_stall | md_stall;
  assign pc_en     = ~stall;
  assign if_id_en  = ~stall;
  assign id_ex_clr = stall;
  assign md_busy   = cnt != '0;
  assign unused    = ^rec;

  assign fwd_rs_d = (int'(rs_d.k) >= 2 && rs_d.tnew == '0)
                    ? rs_d.k : '0;
  assign fwd_rt_d = (int'(rt_d.k) >= 2 && rt_d.tnew == '0)
                    ? rt_d.k : '0;
  assign fwd_rs_e = (rec[1].valid && rec[1].rs_used &&
                     rs_e.k != '0 && rs_e.tnew == '0)
                    ? rs_e.k : '0;
  assign fwd_rt_e = (rec[1].valid && rec[1].rt_used &&
                     rt_e.k != '0 && rt_e.tnew == '0)
                    ? rt_e.k : '0;

  always_comb begin
    rec_nxt = rec;
    for (int k = 2; k <= STAGES; k++) begin
      rec_nxt[k] = rec[k-1];
      if (rec[k-1].tnew != '0)
        rec_nxt[k].tnew = rec[k-1].tnew - TW'(1);
    end
    rec_nxt[1] = '0;
    if (!stall) begin
      rec_nxt[1].valid    = 1'b1;
      rec_nxt[1].wen      = d_wen;
      rec_nxt[1].dst      = d_dst;
      rec_nxt[1].tnew     = d_tnew;
      rec_nxt[1].md_start = d_md_start;
      rec_nxt[1].rs       = d_rs;
      rec_nxt[1].rt       = d_rt;
      rec_nxt[1].rs_used  = d_rs_used;
      rec_nxt[1].rt_used  = d_rt_used;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec <= '0;
      cnt <= '0;
    end else begin
      rec <= rec_nxt;
      if (d_md_start && !stall)
        cnt <= d_md_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
// Bench for hazard_scoreboard: directed vector table, mult/div reset
// sequence, then random stimulus against an age-based reference model.
module tb_hazard_scoreboard;

  localparam int STAGES  = 3;
  localparam int AW      = 5;
  localparam int TW      = 2;
  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 10;
  localparam int SW      = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] d_rs, d_rt, d_dst;
  logic          d_rs_used, d_rt_used;
  logic [TW-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic          d_wen, d_md_start, d_md_div, d_md_use;
  logic          stall, pc_en, if_id_en, id_ex_clr, md_busy;
  logic [SW-1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .STAGES(STAGES), .AW(AW), .TW(TW),
    .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_wen(d_wen), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_use(d_md_use),
    .stall(stall), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_clr(id_ex_clr),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .md_busy(md_busy)
  );

  logic [12:0] act;
  assign act = {stall, pc_en, if_id_en, id_ex_clr,
                fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] rs, rt, dst;
    logic       rsu, rtu, wen, mds, mdd, mdu;
    logic [1:0] rst, rtt, tnew;
    logic       es;
    logic [1:0] frd, frtd, fre, frte;
    logic       eb;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [12:0] pack_exp(
    input logic s, input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] c, input logic [1:0] d, input logic bz);
    return {s, ~s, ~s, s, a, b, c, d, bz};
  endfunction

  function automatic vec_t mk(
    input int rs, input int rsu, input int rst,
    input int rt, input int rtu, input int rtt,
    input int wen, input int dst, input int tnew,
    input int mds, input int mdd, input int mdu,
    input int es, input int frd, input int frtd,
    input int fre, input int frte, input int eb);
    vec_t v;
    v.rs = 5'(rs);  v.rsu = rsu != 0; v.rst = 2'(rst);
    v.rt = 5'(rt);  v.rtu = rtu != 0; v.rtt = 2'(rtt);
    v.wen = wen != 0; v.dst = 5'(dst); v.tnew = 2'(tnew);
    v.mds = mds != 0; v.mdd = mdd != 0; v.mdu = mdu != 0;
    v.es = es != 0;
    v.frd = 2'(frd); v.frtd = 2'(frtd);
    v.fre = 2'(fre); v.frte = 2'(frte);
    v.eb = eb != 0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [12:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b required %b %s", nm, act, e,
        "(stall,pc_en,if_id_en,id_ex_clr,frs_d,frt_d,frs_e,frt_e,busy)");
    end
  endtask

  task automatic drive(input vec_t v);
    d_rs = v.rs; d_rs_used = v.rsu; d_rs_tuse = v.rst;
    d_rt = v.rt; d_rt_used = v.rtu; d_rt_tuse = v.rtt;
    d_wen = v.wen; d_dst = v.dst; d_tnew = v.tnew;
    d_md_start = v.mds; d_md_div = v.mdd; d_md_use = v.mdu;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
  endtask

  // Reference model: every issued instruction carries its age since
  // entering E; remaining latency is just tnew minus age.
  typedef struct {
    logic       wen, mds, rsu, rtu;
    logic [4:0] dst, rs, rt;
    int         tnew0;
    int         age;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   busy_end = 0;

  function automatic void find(input logic [4:0] s, input int min_age,
                               output int stage, output int rem);
    int best;
    best = 1 << 20;
    stage = 0;
    rem = 0;
    foreach (q[i]) begin
      if (q[i].wen && q[i].dst == s && s != 0 &&
          q[i].age >= min_age && q[i].age < best) begin
        best  = q[i].age;
        stage = q[i].age + 1;
        rem   = (q[i].tnew0 > q[i].age) ? q[i].tnew0 - q[i].age : 0;
      end
    end
  endfunction

  function automatic logic [12:0] model_exp();
    int ks, kr, ts, tr, ke, re;
    logic st, busy, e_md;
    logic [1:0] frd, frtd, fre, frte;
    find(d_rs, 0, ks, kr);
    find(d_rt, 0, ts, tr);
    st = (d_rs_used && ks != 0 && kr > int'(d_rs_tuse)) ||
         (d_rt_used && ts != 0 && tr > int'(d_rt_tuse));
    busy = cyc < busy_end;
    e_md = 1'b0;
    fre = 0;
    frte = 0;
    foreach (q[i]) begin
      if (q[i].age == 0) begin
        e_md = q[i].mds;
        if (q[i].rsu) begin
          find(q[i].rs, 1, ke, re);
          if (ke != 0 && re == 0) fre = 2'(ke);
        end
        if (q[i].rtu) begin
          find(q[i].rt, 1, ke, re);
          if (ke != 0 && re == 0) frte = 2'(ke);
        end
      end
    end
    if (d_md_use && (busy || e_md)) st = 1'b1;
    frd  = (ks >= 2 && kr == 0) ? 2'(ks) : 2'd0;
    frtd = (ts >= 2 && tr == 0) ? 2'(ts) : 2'd0;
    return pack_exp(st, frd, frtd, fre, frte, busy);
  endfunction

  task automatic model_advance(input logic st);
    ent_t e;
    for (int i = q.size() - 1; i >= 0; i--) begin
      q[i].age++;
      if (q[i].age >= STAGES) q.delete(i);
    end
    if (!st) begin
      e.wen = d_wen; e.mds = d_md_start;
      e.rsu = d_rs_used; e.rtu = d_rt_used;
      e.dst = d_dst; e.rs = d_rs; e.rt = d_rt;
      e.tnew0 = int'(d_tnew);
      e.age = 0;
      q.push_back(e);
    end
    cyc++;
    if (!st && d_md_start)
      busy_end = cyc + (d_md_div ? DIV_CYC : MUL_CYC);
  endtask

  initial begin
    logic [12:0] e;
    //          rs rsu rst rt rtu rtt wen dst tn mds mdd mdu es frd frtd fre frte eb
    tbl[0]  = mk(0,0,0, 0,0,0, 1,2,2, 0,0,0, 0,0,0,0,0,0);
    tbl[1]  = mk(2,1,1, 0,0,0, 1,3,1, 0,0,0, 1,0,0,0,0,0);
    tbl[2]  = mk(2,1,1, 0,0,0, 1,3,1, 0,0,0, 0,0,0,0,0,0);
    tbl[3]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,3,0,0);
    tbl[4]  = mk(0,0,0, 0,0,0, 1,4,1, 0,0,0, 0,0,0,0,0,0);
    tbl[5]  = mk(4,1,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0,0,0);
    tbl[6]  = mk(4,1,0, 0,0,0, 0,0,0, 0,0,0, 0,2,0,0,0,0);
    tbl[7]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,3,0,0);
    tbl[8]  = mk(0,0,0, 0,0,0, 1,5,0, 0,0,0, 0,0,0,0,0,0);
    tbl[9]  = mk(0,0,0, 0,0,0, 1,5,0, 0,0,0, 0,0,0,0,0,0);
    tbl[10] = mk(5,1,0, 5,1,1, 0,0,0, 0,0,0, 0,0,0,0,0,0);
    tbl[11] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,2,2,0);
    tbl[12] = mk(0,0,0, 0,0,0, 1,0,2, 0,0,0, 0,0,0,0,0,0);
    tbl[13] = mk(0,1,0, 0,1,0, 0,0,0, 0,0,0, 0,0,0,0,0,0);
    tbl[14] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0);
    tbl[15] = mk(0,0,0, 0,0,0, 0,0,0, 1,0,1, 0,0,0,0,0,0);
    tbl[16] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,1, 1,0,0,0,0,1);
    tbl[17] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,1, 1,0,0,0,0,1);
    tbl[18] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,1, 1,0,0,0,0,1);
    tbl[19] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,1, 1,0,0,0,0,1);
    tbl[20] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,1, 1,0,0,0,0,1);
    tbl[21] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,1, 0,0,0,0,0,0);

    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", pack_exp(0, 0, 0, 0, 0, 0));
    d_md_use = 1'b1;
    #1;
    chk("reset_md_use", pack_exp(0, 0, 0, 0, 0, 0));
    idle();
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d", i),
          pack_exp(tbl[i].es, tbl[i].frd, tbl[i].frtd,
                   tbl[i].fre, tbl[i].frte, tbl[i].eb));
      @(posedge clk);
      #1;
    end

    // Divide in flight, counter down to 7, then an asynchronous reset.
    drive(mk(0,0,0, 0,0,0, 0,0,0, 1,1,1, 0,0,0,0,0,0));
    #1;
    chk("div_issue", pack_exp(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("div_busy", pack_exp(0, 0, 0, 0, 0, 1));
    repeat (3) @(posedge clk);
    #1;
    d_md_use = 1'b1;
    #1;
    chk("mfhi_wait_div", pack_exp(1, 0, 0, 0, 0, 1));
    #1;
    reset = 1'b1;
    #1;
    chk("reset_mid_div", pack_exp(0, 0, 0, 0, 0, 0));
    #1;
    reset = 1'b0;
    #1;
    chk("reset_released", pack_exp(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("mfhi_after_reset", pack_exp(0, 0, 0, 0, 0, 0));

    idle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    q.delete();
    busy_end = cyc;

    for (int n = 0; n < 600; n++) begin
      d_rs = 5'($urandom_range(0, 7));
      d_rt = 5'($urandom_range(0, 7));
      d_rs_used = $urandom_range(0, 3) != 0;
      d_rt_used = $urandom_range(0, 2) != 0;
      d_rs_tuse = 2'($urandom_range(0, 3));
      d_rt_tuse = 2'($urandom_range(0, 3));
      d_wen = $urandom_range(0, 3) != 0;
      d_dst = 5'($urandom_range(0, 7));
      d_tnew = 2'($urandom_range(0, 3));
      d_md_start = $urandom_range(0, 9) == 0;
      d_md_div = $urandom_range(0, 1) == 1;
      d_md_use = $urandom_range(0, 4) == 0;
      #1;
      e = model_exp();
      chk("random", e);
      @(posedge clk);
      model_advance(e[12]);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
